prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader that writes 14-bit instruction words into the instruction memory, which the CPU fetch stage reads through its 13-bit program counter. A host shifts in a header word, the data words and a checksum word, one bit per qualified clock. The loader holds the CPU in reset while loading and releases it only after the checksum matches. It sits beside the instruction memory, on the memory's write port.

## Interface

Parameters:
- ADDR_W, 13, instruction memory address width; matches the program counter.
- WORD_W, 14, instruction word width.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high.
- load_req, input, 1, start a load. Sampled in IDLE, DONE and ERR only.
- ser_data, input, 1, serial bit, MSB first.
- ser_valid, input, 1, ser_data is valid this cycle.
- mem_we, output, 1, one-cycle write strobe to instruction memory.
- mem_addr, output, ADDR_W, write address.
- mem_wdata, output, WORD_W, write data.
- cpu_hold, output, 1, holds the CPU in reset; OR it into the CPU reset.
- busy, output, 1, load in progress (states HDR, DATA, CSUM).
- done, output, 1, last load succeeded.
- err, output, 1, last load failed.
- err_code, output, 2, 00 none, 01 zero length, 10 checksum mismatch.
- words_loaded, output, ADDR_W, data words written in the current or last load.

## Operation

- The FSM has six states: IDLE, HDR, DATA, CSUM, DONE, ERR.
- The shift register collects bits only in HDR, DATA and CSUM, and only on cycles with ser_valid=1. A 4-bit counter counts 0..13. The word is complete on the cycle that samples the 14th bit.
- **IDLE / DONE / ERR → HDR** on load_req=1. That cycle clears the bit counter, shift register, checksum, address and words_loaded, plus done, err and err_code. cpu_hold goes to 1.
- **HDR:** on word completion, N = word[12:0] and word[13] is ignored.
  - N=0 → ERR with err_code=01.
  - Otherwise → DATA.
- **DATA:** on each word completion, the word is registered into mem_wdata. The checksum accumulates sum mod 2^14 of the data words. After the N-th word → CSUM.
- **Memory writes:**
  - Each write is one mem_we pulse at the current mem_addr.
  - mem_addr increments after the pulse.
  - words_loaded increments with the pulse.
- **CSUM:** on word completion, compare the received word with the checksum.
  - Equal → DONE: done=1 and cpu_hold=0.
  - Not equal → ERR: err=1, err_code=10 and cpu_hold=0.
- Words already written are not rolled back on error.
- load_req in HDR, DATA or CSUM is ignored.
- ser_valid in IDLE, DONE or ERR is ignored.
- The address wraps mod 2^ADDR_W. N is at most 8191, so the address never wraps within one load.

## Timing

- Reset values:
  - FSM is in IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=0, busy=0, done=0, err=0, err_code=00, words_loaded=0.
- Reset during HDR, DATA or CSUM aborts to IDLE next edge and releases cpu_hold.
- A write pending in the reset cycle is dropped: mem_we=0.
- busy and cpu_hold are 1 from the edge after load_req is sampled.
- mem_we is asserted the cycle after the 14th data bit is sampled, for exactly 1 cycle. mem_addr and mem_wdata are stable during that cycle.
- Writes are at least 14 cycles apart, so there is no back-to-back case.
- On the cycle after the 14th checksum bit:
  - DONE or ERR is entered.
  - busy=0 and cpu_hold=0.
  - done or err is 1 and holds until the next load_req or reset.
- Gaps (ser_valid=0) may appear between any bits. The FSM holds state during gaps; there is no timeout.
- Minimum load time is 14·(N+2) valid cycles plus 1.

## Test plan

- **Nominal 3-word load.** Header 0x0003; data 0x3000, 0x0A05, 0x2805; checksum 0x220A.
  - Three mem_we pulses at addr 0, 1, 2 with the given data.
  - done=1, err_code=00, words_loaded=3.
  - cpu_hold returns to 0.
- **Checksum mismatch.** Same stream with checksum 0x220B.
  - Three writes still occur.
  - err=1, err_code=10, done=0, cpu_hold=0.
- **Zero length.** Header 0x2000, i.e. N=0 with bit 13 set.
  - ERR, err_code=01, no mem_we, words_loaded=0.
- **Gapped serial input.** Nominal stream with random ser_valid=0 gaps up to 5 cycles.
  - Identical writes and final status to the nominal case.
  - load_req pulses mid-load are ignored.
- **Reset mid-load.** Assert reset after the 6th bit of data word 2.
  - Next edge: IDLE, all outputs at reset values, no further mem_we.
  - A following nominal load succeeds from addr 0.
- **Reload after done.** Nominal load, then load_req in DONE with header 0x0001, data 0x1FFF, checksum 0x1FFF.
  - done clears on load_req.
  - One write at addr 0 of 0x1FFF.
  - done=1, words_loaded=1.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: shifts header, data and checksum words in MSB
// first, writes data words to instruction memory and holds the CPU meanwhile.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   load_req          - start a load (honoured in IDLE, DONE, ERR)
//   ser_data/valid    - serial bit stream, one bit per valid cycle
//   mem_we/addr/wdata - instruction memory write port
//   cpu_hold          - OR into the CPU reset while loading
//   busy/done/err     - load status; err_code 01 zero length, 10 checksum
//   words_loaded      - data words written in the current or last load
module prog_loader #(
    parameter int ADDR_W = 13,
    parameter int WORD_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              ser_data,
    input  logic              ser_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

    state_t              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   csum_q, csum_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   words_q, words_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;

    logic                shifting;
    logic                word_done;
    logic [WORD_W-1:0]   word;
    logic [ADDR_W-1:0]   words_inc;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        len_d     = len_q;
        addr_d    = addr_q;
        words_d   = words_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;

        shifting  = (state_q == S_HDR) || (state_q == S_DATA) ||
                    (state_q == S_CSUM);
        word      = {shift_q[WORD_W-2:0], ser_data};
        word_done = shifting && ser_valid && (bit_cnt_q == LAST_BIT);
        words_inc = words_q + 1'b1;

        // Address advances on the cycle after the write strobe.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        if (shifting && ser_valid) begin
            shift_d   = word;
            bit_cnt_d = word_done ? 4'd0 : bit_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d   = S_HDR;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    csum_d    = '0;
                    addr_d    = '0;
                    words_d   = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = 2'b00;
                    hold_d    = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_HDR: begin
                if (word_done) begin
                    len_d = word[ADDR_W-1:0];
                    if (word[ADDR_W-1:0] == '0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        hold_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done) begin
                    wdata_d = word;
                    we_d    = 1'b1;
                    words_d = words_inc;
                    csum_d  = csum_q + word;
                    if (words_inc == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (word_done) begin
                    hold_d = 1'b0;
                    busy_d = 1'b0;
                    if (word == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            csum_q    <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            words_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            csum_q    <= csum_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: expected writes go to a scoreboard queue that a
// negedge monitor drains; load status is checked against a simple model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_valid = 1'b0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [13:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [12:0] words_loaded;

    int vectors = 0;
    int miscompares = 0;
    logic [26:0] exp_q[$];
    logic [12:0] m_addr;
    logic        prev_we = 1'b0;

    prog_loader dut (
        .clk(clk), .reset(reset), .load_req(load_req),
        .ser_data(ser_data), .ser_valid(ser_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next entry.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            chk("we_single", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {6'd0, mem_addr, mem_wdata}, 32'd0);
            end else begin
                chk("write", {5'd0, mem_addr, mem_wdata},
                    {5'd0, exp_q.pop_front()});
            end
        end
        prev_we = (mem_we === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [13:0] w, input int nbits,
                             input int gmax, input bit noise);
        for (int i = 13; i > 13 - nbits; i--) begin
            int g = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
            for (int k = 0; k < g; k++) begin
                ser_valid = 1'b0;
                ser_data  = 1'($urandom);
                load_req  = noise && ($urandom_range(1, 0) == 1);
                tick();
                load_req  = 1'b0;
            end
            ser_valid = 1'b1;
            ser_data  = w[i];
            tick();
            ser_valid = 1'b0;
        end
    endtask

    task automatic idle_noise();
        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1;
            ser_data  = 1'($urandom);
            tick();
        end
        ser_valid = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        m_addr = '0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_done_clr", {30'd0, done, err}, 32'd0);
    endtask

    task automatic finish_chk(input bit ok, input logic [1:0] code,
                              input int n);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_hold", {31'd0, cpu_hold}, 32'd0);
        chk("end_done", {31'd0, done}, {31'd0, ok});
        chk("end_err", {31'd0, err}, {31'd0, ~ok});
        chk("end_code", {30'd0, err_code}, {30'd0, code});
        chk("end_words", {19'd0, words_loaded}, n);
        tick();
        chk("q_drain", exp_q.size(), 0);
    endtask

    task automatic run_load(input logic [13:0] hdr, input logic [13:0] data[$],
                            input logic [13:0] csum, input int gmax,
                            input bit noise);
        int n;
        int sum;
        idle_noise();
        start_load();
        send_bits(hdr, 14, gmax, noise);
        n = int'(hdr[12:0]);
        if (n == 0) begin
            finish_chk(1'b0, 2'b01, 0);
            return;
        end
        sum = 0;
        foreach (data[i]) begin
            exp_q.push_back({m_addr, data[i]});
            m_addr = m_addr + 1'b1;
            sum = (sum + int'(data[i])) % 16384;
            send_bits(data[i], 14, gmax, noise);
        end
        send_bits(csum, 14, gmax, noise);
        if (int'(csum) == sum)
            finish_chk(1'b1, 2'b00, n);
        else
            finish_chk(1'b0, 2'b10, n);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, {19'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {18'd0, mem_wdata}, 32'd0);
        chk({tag, "_status"},
            {26'd0, cpu_hold, busy, done, err, err_code}, 32'd0);
        chk({tag, "_words"}, {19'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        logic [13:0] nom[$];
        logic [13:0] one[$];
        logic [13:0] rd[$];
        logic [13:0] w;
        int s;
        nom = '{14'h3000, 14'h0A05, 14'h2805};
        one = '{14'h1FFF};

        tick();
        tick();
        reset_chk("rst");
        reset = 1'b0;

        run_load(14'h0003, nom, 14'h220A, 0, 1'b0);
        run_load(14'h0003, nom, 14'h220B, 0, 1'b0);
        run_load(14'h2000, nom, 14'h0000, 0, 1'b0);
        run_load(14'h0003, nom, 14'h220A, 5, 1'b1);

        // Reset after the 6th bit of data word 2.
        idle_noise();
        start_load();
        send_bits(14'h0003, 14, 0, 1'b0);
        exp_q.push_back({13'd0, nom[0]});
        send_bits(nom[0], 14, 0, 1'b0);
        send_bits(nom[1], 6, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reset_chk("midrst");
        chk("midrst_q", exp_q.size(), 0);

        // Reset on the same edge as the last data bit drops the write.
        start_load();
        send_bits(14'h0001, 14, 0, 1'b0);
        send_bits(14'h1234, 13, 0, 1'b0);
        ser_valid = 1'b1;
        ser_data  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ser_valid = 1'b0;
        reset_chk("droprst");
        tick();
        chk("drop_we", {31'd0, mem_we}, 32'd0);

        run_load(14'h0003, nom, 14'h220A, 0, 1'b0);
        run_load(14'h0001, one, 14'h1FFF, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(5, 1);
            rd.delete();
            s = 0;
            for (int i = 0; i < n; i++) begin
                w = 14'($urandom);
                rd.push_back(w);
                s = (s + int'(w)) % 16384;
            end
            w = 14'(s);
            if ($urandom_range(2, 0) == 0)
                w = w ^ 14'($urandom_range(16383, 1));
            run_load({1'($urandom), 13'(n)}, rd, w,
                     $urandom_range(3, 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
